sram_link_arbiter: RTL and testbench
====================================

# sram_link_arbiter

Sequences all accesses to the shared 2K x 8 SRAM and arbitrates it between two requesters: the Nios II software path (single read/write requests) and the serial-link receive path, whose bytes are stored autonomously into a ring buffer in SRAM. It sits between the system's SRAM-bus and link PIOs and the SRAM itself. It guarantees fixed-length, glitch-free bus cycles and ensures no received byte is lost silently.

## Interface
- ACCESS_CYCLES, 2: cycles `sram_cs` is held high per access; legal range 1..15.
- RING_BASE, 11'h700: ring base address; must be a multiple of RING_DEPTH.
- RING_DEPTH, 256: ring size in bytes; power of two, 2..1024.
- clk_clk  in  1  system clock; all logic is rising-edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  level request; held high until `cpu_ack`.
- cpu_rnw  in  1  1 = read, 0 = write; stable while `cpu_req` is high.
- cpu_addr  in  11  access address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid from `cpu_ack` until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- rx_valid  in  1  one-cycle strobe per received byte; already synchronous to clk_clk.
- rx_data  in  8  received byte, qualified by `rx_valid`.
- rd_ptr  in  log2(RING_DEPTH)  software ring read pointer.
- ovf_clr  in  1  clears `rx_overflow`.
- wr_ptr  out  log2(RING_DEPTH)  next ring slot to be written.
- ring_count  out  log2(RING_DEPTH)  bytes in the ring, `(wr_ptr - rd_ptr) mod RING_DEPTH`.
- rx_overflow  out  1  sticky flag for a dropped byte.
- sram_addr  out  11  SRAM address.
- sram_cs  out  1  chip select, active high.
- sram_rnw  out  1  1 = read, 0 = write.
- sram_wdata  out  8  write data.
- sram_oe  out  1  write-data drive enable for the bidirectional pad.
- sram_rdata  in  8  SRAM read data.

## Operation
- RX holding register (one byte plus a pending bit):
  - `rx_valid` is accepted when the register is empty and `ring_count` is below RING_DEPTH-1.
  - Otherwise the byte is dropped and `rx_overflow` is set.
  - The ring therefore holds at most RING_DEPTH-1 bytes; one slot is always empty.
  - If `rx_valid` arrives in the same cycle the pending byte is granted, it is accepted.
- Arbitration is done in IDLE only, with fixed priority: RX pending first, then `cpu_req`.
  - CPU is delayed by at most one RX access, because RX bytes arrive far slower than bus cycles.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
  - IDLE -> SETUP on a grant: latch address, rnw and write data. RX address is `RING_BASE | wr_ptr`, always a write.
  - SETUP -> ACCESS after 1 cycle.
  - ACCESS lasts ACCESS_CYCLES cycles, then -> HOLD.
  - HOLD -> IDLE after 1 cycle.
- Bus signals:
  - `sram_addr`, `sram_rnw` and `sram_wdata` are stable from SETUP through HOLD.
  - `sram_cs` is high only in ACCESS.
  - `sram_oe` is high from SETUP through HOLD, on writes only.
- Reads: `sram_rdata` is captured on the last ACCESS cycle into `cpu_rdata`.
- Completion in HOLD:
  - CPU grant: `cpu_ack` pulses.
  - RX grant: `wr_ptr` increments, wrapping RING_DEPTH-1 -> 0, and the pending bit clears.
- The CPU may read any address, including the ring region. The block does not check `rd_ptr`; software owns it.
- `ovf_clr` takes priority over setting `rx_overflow` in the same cycle.

## Timing
- Reset values:
  - `sram_cs`=0, `sram_rnw`=1, `sram_oe`=0; `sram_addr`, `sram_wdata`, `cpu_rdata` = 0.
  - `cpu_ack`=0, `wr_ptr`=0, `rx_overflow`=0, pending cleared, FSM in IDLE.
  - Reset asserted mid-access forces these values immediately, without waiting for a clock edge.
  - A CPU request in flight at reset is abandoned without `cpu_ack`.
- Latency: `cpu_req` sampled high in IDLE at edge 0 -> `cpu_ack` high in cycle 2+ACCESS_CYCLES.
- Back-to-back: minimum access period is 3+ACCESS_CYCLES cycles, including the IDLE cycle.
- `ring_count` is combinational from the `wr_ptr` and `rd_ptr` registers.
- `rx_valid` to `wr_ptr` update: at most 2×(3+ACCESS_CYCLES) cycles, when a CPU access is in progress.

## Structure
- Package `sram_arb_pkg` holds:
  - the FSM state enum;
  - the default ACCESS_CYCLES, RING_BASE and RING_DEPTH constants;
  - the SRAM address and data width constants (11, 8).
- Sub-module `rx_ring_ptr` holds `wr_ptr`, the `ring_count` and full computation, the holding register and the overflow flag. The top level holds the FSM and the bus registers.

## Test plan
- Reset: hold `reset_reset_n` low mid-ACCESS -> `sram_cs`=0, `sram_rnw`=1 immediately, with no clock edge; all other outputs at their reset values.
- CPU write, then read, with ACCESS_CYCLES=2:
  - Write 0x5A to 0x123: `sram_cs` high in cycles 2–3, `sram_rnw`=0, `sram_oe`=1, `cpu_ack` in cycle 4.
  - Read of 0x123 then returns `cpu_rdata`=0x5A.
- RX store: `rx_valid` with 0x41 in IDLE -> write to 0x700; then `wr_ptr`=1, `ring_count`=1.
- Contention: RX pending and `cpu_req` in the same IDLE cycle -> RX write first; `cpu_ack` arrives 5 cycles after the RX HOLD.
- Overflow: `rx_valid` in two consecutive cycles during a CPU access -> second byte dropped, `rx_overflow`=1; `ovf_clr` -> 0.
- Full and wrap:
  - With `rd_ptr`=0, send 256 bytes -> 255 stored, `ring_count`=255, last byte dropped, `rx_overflow`=1.
  - Set `rd_ptr`=10 -> next byte writes 0x7FF and `wr_ptr` becomes 0; the following byte writes 0x700.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the SRAM / serial-link arbiter.
package sram_arb_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    localparam int                DEF_ACCESS_CYCLES = 2;
    localparam logic [ADDR_W-1:0] DEF_RING_BASE     = 11'h700;
    localparam int                DEF_RING_DEPTH    = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } arb_state_t;

endpackage

// File: rtl/rx_ring_ptr.sv
// Receive-side ring bookkeeping: holding register, write pointer, fill level
// and the sticky overflow flag.
module rx_ring_ptr
    import sram_arb_pkg::*;
#(
    parameter int RING_DEPTH = DEF_RING_DEPTH,
    parameter int PW         = $clog2(RING_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rstN,
    input  logic              i_rxValid,
    input  logic [DATA_W-1:0] i_rxData,
    input  logic [PW-1:0]     i_rdPtr,
    input  logic              i_ovfClr,
    input  logic              i_grant,
    input  logic              i_commit,
    output logic [PW-1:0]     o_wrPtr,
    output logic [PW-1:0]     o_ringCount,
    output logic              o_rxOverflow,
    output logic              o_pending,
    output logic [DATA_W-1:0] o_heldData
);

    localparam logic [PW:0] FULL_LEVEL = (PW+1)'(RING_DEPTH - 1);

    logic [PW-1:0]     r_wrPtr;
    logic              r_pending;
    logic              r_inflight;
    logic              r_overflow;
    logic [DATA_W-1:0] r_heldData;

    logic [PW-1:0] w_ringCount;
    logic [PW:0]   w_occupancy;
    logic          w_slotBusy;
    logic          w_accept;

    // A byte already granted but not yet committed still owns a ring slot,
    // so it counts toward the fill level used for the accept decision.
    assign w_ringCount = r_wrPtr - i_rdPtr;
    assign w_occupancy = {1'b0, w_ringCount} + {{PW{1'b0}}, r_inflight}
                       + {{PW{1'b0}}, r_pending};
    assign w_slotBusy  = r_pending && !i_grant;
    assign w_accept    = i_rxValid && !w_slotBusy && (w_occupancy < FULL_LEVEL);

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_wrPtr    <= '0;
            r_pending  <= 1'b0;
            r_inflight <= 1'b0;
            r_overflow <= 1'b0;
            r_heldData <= '0;
        end else begin
            if (w_accept) begin
                r_pending  <= 1'b1;
                r_heldData <= i_rxData;
            end else if (i_grant) begin
                r_pending  <= 1'b0;
            end

            if (i_grant) begin
                r_inflight <= 1'b1;
            end else if (i_commit) begin
                r_inflight <= 1'b0;
            end

            if (i_commit) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end

            if (i_ovfClr) begin
                r_overflow <= 1'b0;
            end else if (i_rxValid && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_wrPtr      = r_wrPtr;
    assign o_ringCount  = w_ringCount;
    assign o_rxOverflow = r_overflow;
    assign o_pending    = r_pending;
    assign o_heldData   = r_heldData;

endmodule

// File: rtl/sram_link_arbiter.sv
// Sequences fixed-length SRAM bus cycles and arbitrates the SRAM between the
// serial-link ring writer (priority) and single CPU read/write requests.
module sram_link_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter logic [ADDR_W-1:0] RING_BASE     = DEF_RING_BASE,
    parameter int                RING_DEPTH    = DEF_RING_DEPTH,
    localparam int               PW            = $clog2(RING_DEPTH)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [PW-1:0]     rd_ptr,
    input  logic              ovf_clr,
    output logic [PW-1:0]     wr_ptr,
    output logic [PW-1:0]     ring_count,
    output logic              rx_overflow,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_cs,
    output logic              sram_rnw,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic [3:0]        r_accessCnt;
    logic              r_grantRx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rnw;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cs;
    logic              r_oe;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;

    logic              w_grantRx;
    logic              w_grantCpu;
    logic              w_grant;
    logic              w_nextRnw;
    logic              w_lastAccess;
    logic              w_rxCommit;
    logic              w_rxPending;
    logic [DATA_W-1:0] w_rxHeld;
    logic [PW-1:0]     w_wrPtr;
    logic [ADDR_W-1:0] w_ringAddr;

    rx_ring_ptr #(
        .RING_DEPTH (RING_DEPTH),
        .PW         (PW)
    ) u_rxRing (
        .i_clk        (clk_clk),
        .i_rstN       (reset_reset_n),
        .i_rxValid    (rx_valid),
        .i_rxData     (rx_data),
        .i_rdPtr      (rd_ptr),
        .i_ovfClr     (ovf_clr),
        .i_grant      (w_grantRx),
        .i_commit     (w_rxCommit),
        .o_wrPtr      (w_wrPtr),
        .o_ringCount  (ring_count),
        .o_rxOverflow (rx_overflow),
        .o_pending    (w_rxPending),
        .o_heldData   (w_rxHeld)
    );

    assign w_ringAddr   = RING_BASE | {{(ADDR_W-PW){1'b0}}, w_wrPtr};
    assign w_grant      = w_grantRx | w_grantCpu;
    assign w_lastAccess = (r_state == ST_ACCESS) && (r_accessCnt == 4'd0);
    assign w_rxCommit   = (r_state == ST_HOLD) && r_grantRx;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= ST_IDLE;
            r_accessCnt <= 4'd0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_SETUP) begin
                r_accessCnt <= CNT_LOAD;
            end else if ((r_state == ST_ACCESS) && (r_accessCnt != 4'd0)) begin
                r_accessCnt <= r_accessCnt - 4'd1;
            end
        end
    end

    // Grants are only issued from IDLE; the receive path always wins a tie.
    always_comb begin
        w_nextState = r_state;
        w_grantRx   = 1'b0;
        w_grantCpu  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rxPending) begin
                    w_grantRx   = 1'b1;
                    w_nextState = ST_SETUP;
                end else if (cpu_req) begin
                    w_grantCpu  = 1'b1;
                    w_nextState = ST_SETUP;
                end
            end
            ST_SETUP:  w_nextState = ST_ACCESS;
            ST_ACCESS: begin
                if (r_accessCnt == 4'd0) begin
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
        w_nextRnw = w_grant ? (w_grantCpu & cpu_rnw) : r_rnw;
    end

    // Bus strobes are registered from the next state so the pins never glitch.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_addr    <= '0;
            r_rnw     <= 1'b1;
            r_wdata   <= '0;
            r_cs      <= 1'b0;
            r_oe      <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_grantRx <= 1'b0;
        end else begin
            if (w_grant) begin
                r_addr    <= w_grantRx ? w_ringAddr : cpu_addr;
                r_rnw     <= w_nextRnw;
                r_wdata   <= w_grantRx ? w_rxHeld : cpu_wdata;
                r_grantRx <= w_grantRx;
            end
            r_cs  <= (w_nextState == ST_ACCESS);
            r_oe  <= (w_nextState != ST_IDLE) && !w_nextRnw;
            r_ack <= (w_nextState == ST_HOLD) && !r_grantRx;
            if (w_lastAccess && r_rnw) begin
                r_rdata <= sram_rdata;
            end
        end
    end

    assign sram_addr  = r_addr;
    assign sram_rnw   = r_rnw;
    assign sram_wdata = r_wdata;
    assign sram_cs    = r_cs;
    assign sram_oe    = r_oe;
    assign cpu_ack    = r_ack;
    assign cpu_rdata  = r_rdata;
    assign wr_ptr     = w_wrPtr;

endmodule

// File: tb/tb_sram_link_arbiter.sv
// Directed bench for sram_link_arbiter with a behavioural 2K x 8 SRAM model.
module tb_sram_link_arbiter;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  rd_ptr;
    logic        ovf_clr;
    logic [7:0]  wr_ptr;
    logic [7:0]  ring_count;
    logic        rx_overflow;
    logic [10:0] sram_addr;
    logic        sram_cs;
    logic        sram_rnw;
    logic [7:0]  sram_wdata;
    logic        sram_oe;
    logic [7:0]  sram_rdata;

    logic [7:0]  mem [0:2047];
    logic [10:0] lastWrAddr;
    logic [7:0]  lastWrData;

    int total;
    int bad;

    sram_link_arbiter dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cpu_req       (cpu_req),
        .cpu_rnw       (cpu_rnw),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ack       (cpu_ack),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rd_ptr        (rd_ptr),
        .ovf_clr       (ovf_clr),
        .wr_ptr        (wr_ptr),
        .ring_count    (ring_count),
        .rx_overflow   (rx_overflow),
        .sram_addr     (sram_addr),
        .sram_cs       (sram_cs),
        .sram_rnw      (sram_rnw),
        .sram_wdata    (sram_wdata),
        .sram_oe       (sram_oe),
        .sram_rdata    (sram_rdata)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // SRAM model: writes land on any clock edge with chip select high.
    always @(posedge clk_clk) begin
        if (sram_cs && !sram_rnw) begin
            mem[sram_addr] <= sram_wdata;
            lastWrAddr     <= sram_addr;
            lastWrData     <= sram_wdata;
        end
    end
    assign sram_rdata = (sram_cs && sram_rnw) ? mem[sram_addr] : 8'h00;

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitAck(input string tag);
        int n;
        n = 0;
        while (!cpu_ack && n < 40) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, 32'(cpu_ack), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total         = 0;
        bad           = 0;
        reset_reset_n = 1'b0;
        cpu_req       = 1'b0;
        cpu_rnw       = 1'b1;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        rx_valid      = 1'b0;
        rx_data       = '0;
        rd_ptr        = '0;
        ovf_clr       = 1'b0;

        applyStimulus(2);
        checkOutput("rst_cs",    32'(sram_cs),     32'd0);
        checkOutput("rst_rnw",   32'(sram_rnw),    32'd1);
        checkOutput("rst_oe",    32'(sram_oe),     32'd0);
        checkOutput("rst_addr",  32'(sram_addr),   32'd0);
        checkOutput("rst_ack",   32'(cpu_ack),     32'd0);
        checkOutput("rst_wrptr", 32'(wr_ptr),      32'd0);
        checkOutput("rst_ovf",   32'(rx_overflow), 32'd0);
        reset_reset_n = 1'b1;
        applyStimulus(1);

        $display("[TB] cpu write 0x5A -> 0x123");
        cpu_req   = 1'b1;
        cpu_rnw   = 1'b0;
        cpu_addr  = 11'h123;
        cpu_wdata = 8'h5A;
        applyStimulus(1);
        checkOutput("wr_c1_cs",   32'(sram_cs),    32'd0);
        checkOutput("wr_c1_oe",   32'(sram_oe),    32'd1);
        checkOutput("wr_c1_rnw",  32'(sram_rnw),   32'd0);
        checkOutput("wr_c1_addr", 32'(sram_addr),  32'h123);
        checkOutput("wr_c1_data", 32'(sram_wdata), 32'h5A);
        applyStimulus(1);
        checkOutput("wr_c2_cs",   32'(sram_cs),    32'd1);
        applyStimulus(1);
        checkOutput("wr_c3_cs",   32'(sram_cs),    32'd1);
        checkOutput("wr_c3_ack",  32'(cpu_ack),    32'd0);
        applyStimulus(1);
        checkOutput("wr_c4_ack",  32'(cpu_ack),    32'd1);
        checkOutput("wr_c4_cs",   32'(sram_cs),    32'd0);
        checkOutput("wr_c4_oe",   32'(sram_oe),    32'd1);
        cpu_req = 1'b0;
        applyStimulus(1);
        checkOutput("wr_c5_ack",  32'(cpu_ack),    32'd0);
        checkOutput("wr_mem",     32'(mem[11'h123]), 32'h5A);

        $display("[TB] cpu read 0x123");
        cpu_req = 1'b1;
        cpu_rnw = 1'b1;
        applyStimulus(1);
        checkOutput("rd_oe",  32'(sram_oe),  32'd0);
        checkOutput("rd_rnw", 32'(sram_rnw), 32'd1);
        waitAck("rd_ack");
        checkOutput("rd_data", 32'(cpu_rdata), 32'h5A);
        cpu_req = 1'b0;
        applyStimulus(1);

        $display("[TB] rx store 0x41");
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        applyStimulus(1);
        rx_valid = 1'b0;
        applyStimulus(1);
        checkOutput("rx_addr", 32'(sram_addr),  32'h700);
        checkOutput("rx_data", 32'(sram_wdata), 32'h41);
        checkOutput("rx_rnw",  32'(sram_rnw),   32'd0);
        applyStimulus(4);
        checkOutput("rx_wrptr", 32'(wr_ptr),       32'd1);
        checkOutput("rx_count", 32'(ring_count),   32'd1);
        checkOutput("rx_mem",   32'(mem[11'h700]), 32'h41);

        $display("[TB] contention rx vs cpu");
        rx_valid = 1'b1;
        rx_data  = 8'h42;
        applyStimulus(1);
        rx_valid = 1'b0;
        cpu_req  = 1'b1;
        cpu_rnw  = 1'b1;
        cpu_addr = 11'h123;
        applyStimulus(1);
        checkOutput("ct_addr", 32'(sram_addr), 32'h701);
        checkOutput("ct_rnw",  32'(sram_rnw),  32'd0);
        applyStimulus(3);
        checkOutput("ct_hold_ack",   32'(cpu_ack), 32'd0);
        checkOutput("ct_hold_wrptr", 32'(wr_ptr),  32'd1);
        applyStimulus(4);
        checkOutput("ct_early_ack", 32'(cpu_ack), 32'd0);
        applyStimulus(1);
        checkOutput("ct_ack",   32'(cpu_ack),   32'd1);
        checkOutput("ct_rdata", 32'(cpu_rdata), 32'h5A);
        cpu_req = 1'b0;
        applyStimulus(1);
        checkOutput("ct_wrptr", 32'(wr_ptr),       32'd2);
        checkOutput("ct_mem",   32'(mem[11'h701]), 32'h42);

        $display("[TB] overflow during cpu access");
        cpu_req   = 1'b1;
        cpu_rnw   = 1'b0;
        cpu_addr  = 11'h050;
        cpu_wdata = 8'h33;
        applyStimulus(1);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        applyStimulus(1);
        rx_data  = 8'h78;
        applyStimulus(1);
        rx_valid = 1'b0;
        checkOutput("ov_flag", 32'(rx_overflow), 32'd1);
        waitAck("ov_ack");
        cpu_req = 1'b0;
        applyStimulus(8);
        checkOutput("ov_wrptr",  32'(wr_ptr),       32'd3);
        checkOutput("ov_mem",    32'(mem[11'h702]), 32'h77);
        checkOutput("ov_last",   32'(lastWrData),   32'h77);
        checkOutput("ov_sticky", 32'(rx_overflow),  32'd1);
        ovf_clr = 1'b1;
        applyStimulus(1);
        ovf_clr = 1'b0;
        checkOutput("ov_clr", 32'(rx_overflow), 32'd0);

        $display("[TB] async reset mid access");
        cpu_req  = 1'b1;
        cpu_rnw  = 1'b1;
        cpu_addr = 11'h123;
        applyStimulus(2);
        checkOutput("ar_cs_before", 32'(sram_cs), 32'd1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        checkOutput("ar_cs",    32'(sram_cs),   32'd0);
        checkOutput("ar_rnw",   32'(sram_rnw),  32'd1);
        checkOutput("ar_oe",    32'(sram_oe),   32'd0);
        checkOutput("ar_addr",  32'(sram_addr), 32'd0);
        checkOutput("ar_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("ar_wrptr", 32'(wr_ptr),    32'd0);
        checkOutput("ar_ack",   32'(cpu_ack),   32'd0);
        cpu_req = 1'b0;
        @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        applyStimulus(3);
        checkOutput("ar_no_ack", 32'(cpu_ack), 32'd0);
        checkOutput("ar_idle_cs", 32'(sram_cs), 32'd0);

        $display("[TB] ring full and wrap");
        rd_ptr = 8'd0;
        for (int i = 0; i < 256; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            applyStimulus(1);
            rx_valid = 1'b0;
            applyStimulus(7);
        end
        checkOutput("full_count", 32'(ring_count),  32'd255);
        checkOutput("full_wrptr", 32'(wr_ptr),      32'd255);
        checkOutput("full_ovf",   32'(rx_overflow), 32'd1);
        checkOutput("full_laddr", 32'(lastWrAddr),  32'h7FE);
        checkOutput("full_ldata", 32'(lastWrData),  32'hFE);

        ovf_clr  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        applyStimulus(1);
        ovf_clr  = 1'b0;
        rx_valid = 1'b0;
        checkOutput("clr_prio_ovf",   32'(rx_overflow), 32'd0);
        applyStimulus(7);
        checkOutput("clr_prio_wrptr", 32'(wr_ptr),      32'd255);

        rd_ptr = 8'd10;
        #1;
        checkOutput("rd10_count", 32'(ring_count), 32'd245);
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        applyStimulus(1);
        rx_valid = 1'b0;
        applyStimulus(7);
        checkOutput("wrap_laddr", 32'(lastWrAddr),   32'h7FF);
        checkOutput("wrap_mem",   32'(mem[11'h7FF]), 32'hAB);
        checkOutput("wrap_wrptr", 32'(wr_ptr),       32'd0);
        checkOutput("wrap_count", 32'(ring_count),   32'd246);
        rx_valid = 1'b1;
        rx_data  = 8'hCD;
        applyStimulus(1);
        rx_valid = 1'b0;
        applyStimulus(7);
        checkOutput("post_laddr", 32'(lastWrAddr), 32'h700);
        checkOutput("post_ldata", 32'(lastWrData), 32'hCD);
        checkOutput("post_wrptr", 32'(wr_ptr),     32'd1);
        checkOutput("post_count", 32'(ring_count), 32'd247);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
